// File: rtl/mcd_addr_cache.sv
// Address cache between memcached and the PCIe allocator: FWFT address FIFO with free-address recycling and flush sequencing.
// Optional statistics counters are enabled by defining ADDR_CACHE_STATS_EN.
module mcd_addr_cache #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              axi_clk,
  input  logic              axi_resetn,
  input  logic [DATA_W-1:0] alloc_in_data,
  input  logic              alloc_in_valid,
  output logic              alloc_in_ready,
  output logic [DATA_W-1:0] mcd_addr_data,
  output logic              mcd_addr_valid,
  input  logic              mcd_addr_ready,
  input  logic [DATA_W-1:0] mcd_free_data,
  input  logic              mcd_free_valid,
  output logic              mcd_free_ready,
  output logic [DATA_W-1:0] rec_out_data,
  output logic              rec_out_valid,
  input  logic              rec_out_ready,
  input  logic              mcd_flush_req,
  output logic              mcd_flush_ack,
  input  logic              mcd_flush_done,
  output logic              alloc_flush_req,
  input  logic              alloc_flush_ack,
  output logic              alloc_flush_done,
  output logic [31:0]       stat_recycled,
  output logic [31:0]       stat_forwarded
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_CLEAR     = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               alloc_flush_req_q, alloc_flush_req_d;
  logic               mcd_flush_ack_q, mcd_flush_ack_d;
  logic               alloc_flush_done_q, alloc_flush_done_d;

  logic               run_c;
  logic               full_c;
  logic               pop_c;
  logic               room_c;
  logic               recycle_c;
  logic               push_c;
  logic [DATA_W-1:0]  wdata_c;

  // FIFO handshakes; reset is folded in so every output reads 0 while held in reset
  always_comb begin
    run_c          = (state_q == ST_RUN) && axi_resetn;
    full_c         = (count_q == CNT_W'(DEPTH));
    mcd_addr_valid = run_c && (count_q != '0);
    mcd_addr_data  = mcd_addr_valid ? mem_q[rd_ptr_q] : '0;
    pop_c          = mcd_addr_valid && mcd_addr_ready;
    room_c         = !full_c || pop_c;
    mcd_free_ready = run_c && (room_c || rec_out_ready);
    rec_out_valid  = run_c && mcd_free_valid && !room_c;
    rec_out_data   = rec_out_valid ? mcd_free_data : '0;
    alloc_in_ready = run_c && room_c && !mcd_free_valid;
    recycle_c      = mcd_free_valid && mcd_free_ready && room_c;
    push_c         = recycle_c || (alloc_in_valid && alloc_in_ready);
    wdata_c        = recycle_c ? mcd_free_data : alloc_in_data;
  end

  // Pointer and occupancy update; CLEAR discards everything in flight
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (state_q == ST_CLEAR) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge axi_clk) begin
    if (push_c) mem_q[wr_ptr_q] <= wdata_c;
  end

  // Flush FSM: state register and registered handshake outputs
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q            <= ST_RUN;
      alloc_flush_req_q  <= 1'b0;
      mcd_flush_ack_q    <= 1'b0;
      alloc_flush_done_q <= 1'b0;
    end else begin
      state_q            <= state_d;
      alloc_flush_req_q  <= alloc_flush_req_d;
      mcd_flush_ack_q    <= mcd_flush_ack_d;
      alloc_flush_done_q <= alloc_flush_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:       if (mcd_flush_req) state_d = ST_CLEAR;
      ST_CLEAR:     state_d = ST_WAIT_ACK;
      ST_WAIT_ACK:  if (alloc_flush_ack) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (mcd_flush_done) state_d = ST_DONE;
      ST_DONE:      if (!alloc_flush_ack && !mcd_flush_req) state_d = ST_RUN;
      default:      state_d = ST_RUN;
    endcase
  end

  // Flush outputs decoded from the next state so they line up with the state register
  always_comb begin
    alloc_flush_req_d  = 1'b0;
    mcd_flush_ack_d    = 1'b0;
    alloc_flush_done_d = 1'b0;
    case (state_d)
      ST_WAIT_ACK:  alloc_flush_req_d  = 1'b1;
      ST_WAIT_DONE: mcd_flush_ack_d    = 1'b1;
      ST_DONE:      alloc_flush_done_d = 1'b1;
      default:      ;
    endcase
  end

  assign alloc_flush_req  = alloc_flush_req_q;
  assign mcd_flush_ack    = mcd_flush_ack_q;
  assign alloc_flush_done = alloc_flush_done_q;

`ifdef ADDR_CACHE_STATS_EN
  logic [31:0] stat_rec_q, stat_rec_d;
  logic [31:0] stat_fwd_q, stat_fwd_d;

  // Recycle / forward counters, wrapping at 2^32
  always_comb begin
    stat_rec_d = stat_rec_q;
    stat_fwd_d = stat_fwd_q;
    if (state_q == ST_CLEAR) begin
      stat_rec_d = '0;
      stat_fwd_d = '0;
    end else begin
      if (recycle_c) stat_rec_d = stat_rec_q + 32'd1;
      if (rec_out_valid && rec_out_ready) stat_fwd_d = stat_fwd_q + 32'd1;
    end
  end

  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      stat_rec_q <= '0;
      stat_fwd_q <= '0;
    end else begin
      stat_rec_q <= stat_rec_d;
      stat_fwd_q <= stat_fwd_d;
    end
  end

  assign stat_recycled  = stat_rec_q;
  assign stat_forwarded = stat_fwd_q;
`else
  assign stat_recycled  = '0;
  assign stat_forwarded = '0;
`endif

endmodule

// File: doc/mcd_addr_cache.md
Name: mcd_addr_cache

Overview:
- Address cache between the memcached pipeline and the PCIe memory allocator.
- Prefetches allocator-issued DRAM addresses into a local FIFO, so memcached sees zero-latency address grants.
- Recycles addresses memcached frees straight back into the FIFO; only overflow goes back across PCIe for reclamation.
- Sequences the flush handshake between memcached and the allocator.

Parameters:
DEPTH, 16, FIFO entries; power of 2, at least 4
DATA_W, 32, address width
CNT_W, 5, occupancy counter width; equals log2(DEPTH)+1

Ports:
axi_clk  in  1  clock
axi_resetn  in  1  asynchronous active-low reset
alloc_in_data  in  DATA_W  address from allocator
alloc_in_valid  in  1  allocator address valid
alloc_in_ready  out  1  cache accepts allocator address
mcd_addr_data  out  DATA_W  address granted to memcached
mcd_addr_valid  out  1  grant valid
mcd_addr_ready  in  1  memcached consumes grant
mcd_free_data  in  DATA_W  address freed by memcached
mcd_free_valid  in  1  free valid
mcd_free_ready  out  1  free accepted
rec_out_data  out  DATA_W  overflow free address to allocator
rec_out_valid  out  1  overflow valid
rec_out_ready  in  1  allocator accepts overflow
mcd_flush_req  in  1  flush request from memcached (level)
mcd_flush_ack  out  1  ack to memcached (level)
mcd_flush_done  in  1  flush done from memcached (level)
alloc_flush_req  out  1  flush request to allocator
alloc_flush_ack  in  1  ack from allocator
alloc_flush_done  out  1  done to allocator
stat_recycled  out  32  recycled-address count (optional)
stat_forwarded  out  32  forwarded-address count (optional)

Behaviour:
- Reset: all outputs 0; FIFO empty, count=0; state RUN.
- FIFO is first-word-fall-through with one write port and one read port.
  - mcd_addr_valid = (state==RUN) && count!=0; mcd_addr_data = entry at head.
  - A written word is visible at the head on the next cycle.
- Write-port arbitration in RUN:
  - Recycle has priority over alloc_in.
  - recycle = mcd_free_valid && mcd_free_ready && count_next_room, where room means count < DEPTH, or count==DEPTH with a simultaneous pop.
  - mcd_free_ready = RUN && (room || rec_out_ready).
  - With no room, the free is forwarded combinationally: rec_out_valid = RUN && mcd_free_valid && !room; rec_out_data = mcd_free_data.
  - alloc_in_ready = RUN && room && !(mcd_free_valid).
- Count:
  - +1 on push only, -1 on pop only, unchanged on both.
  - Never exceeds DEPTH; pop on empty is impossible because valid=0.
  - Pointers wrap modulo DEPTH.
- Flush state machine:
  - RUN → CLEAR when mcd_flush_req=1.
  - CLEAR (1 cycle): pointers and count reset to 0; all ready/valid outputs 0; goes to WAIT_ACK.
  - WAIT_ACK: alloc_flush_req=1; when alloc_flush_ack=1, go to WAIT_DONE.
  - WAIT_DONE: alloc_flush_req=0, mcd_flush_ack=1. When mcd_flush_done=1, go to DONE.
  - DONE: alloc_flush_done=1, mcd_flush_ack=0. When alloc_flush_ack=0 and mcd_flush_req=0, go to RUN.
  - Outside RUN, all FIFO handshakes (alloc_in_ready, mcd_addr_valid, mcd_free_ready, rec_out_valid) are 0.
  - A flush request arriving in the same cycle as a push or pop: the flush wins. The transaction completes that cycle, then CLEAR discards it.
- Reset mid-operation: immediate return to reset state; any in-flight addresses are lost, the same as a flush.

Optional Feature:
- Macro ADDR_CACHE_STATS_EN.
- Defined:
  - stat_recycled increments on each recycle push.
  - stat_forwarded increments on each rec_out handshake.
  - Both counters are 32-bit, wrap at 2^32, and are cleared by reset and by CLEAR.
- Undefined: both stat outputs are tied to 0 and no counter logic is generated.

Test Plan:
- Prefetch: allocator pushes 0x100,0x104,0x108 with mcd_addr_ready=0 → count=3, alloc_in_ready stays 1. Then ready=1 → grants 0x100,0x104,0x108 on consecutive cycles, then valid=0.
- Fill: DEPTH=16, allocator pushes 16 addresses → alloc_in_ready=0 at count=16. Free 0x500 with rec_out_ready=1 → rec_out_data=0x500 same cycle; with stats enabled, stat_forwarded=1.
- Recycle priority: count=4, mcd_free 0x900 and alloc_in 0x200 valid same cycle → 0x900 written, alloc_in_ready=0, 0x200 accepted next cycle; stat_recycled=1.
- Full with simultaneous pop and free: count=16, pop and free 0xA00 same cycle → recycle written, count stays 16, rec_out_valid=0.
- Flush: count=5, assert mcd_flush_req → count=0 after 1 cycle, alloc_flush_req=1. alloc_flush_ack=1 → mcd_flush_ack=1. mcd_flush_done=1 → alloc_flush_done=1. Drop ack and req → RUN, alloc_in_ready=1.
- Async reset: assert axi_resetn=0 in WAIT_ACK between clock edges → all outputs 0 immediately; after release, RUN with count=0.
